aer_rank_decoder: RTL

- Receiving end of the 4-phase AER output link driven by the image encoder.
- Accepts one pixel-ID event per handshake and acknowledges it. Rebuilds a rank-order image: earlier events give higher intensity.
- Flags frame completion after IMAGE_SIZE valid events. Used for loopback checking of the encoder and as the input-layer front end of the SNN core.

---
 rtl/aer_rank_decoder_if.sv | 15 +
 rtl/aer_rank_decoder.sv | 112 +++++++++++
 2 files changed

// File: rtl/aer_rank_decoder_if.sv
// AER event link between the image encoder (master) and the rank decoder (slave).
// Carries the pixel-ID bus, the request and the acknowledge of one 4-phase handshake.
interface aer_rank_decoder_if #(
    parameter int ADDR_BITS = 9
);
    // 4-phase handshake: master drives AERIN_ADDR and raises AERIN_REQ; ADDR stays stable
    // while REQ is high. Slave raises AERIN_ACK once the event is taken; master then drops
    // REQ, slave drops ACK, and only then may the master present the next event.
    logic [ADDR_BITS-1:0] AERIN_ADDR;
    logic                 AERIN_REQ;
    logic                 AERIN_ACK;

    modport master (output AERIN_ADDR, output AERIN_REQ, input AERIN_ACK);
    modport slave  (input AERIN_ADDR, input AERIN_REQ, output AERIN_ACK);
endinterface

// File: rtl/aer_rank_decoder.sv
// Receiving end of the AER link: rebuilds a rank-order image where earlier events
// get higher intensity, and flags frame completion, bad addresses and duplicates.
module aer_rank_decoder #(
    parameter int IMAGE_SIZE      = 256,
    parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
    parameter int PIXEL_MAX_VALUE = 255,
    parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     NEW_FRAME,
    aer_rank_decoder_if.slave        AERIN,
    output logic [PIXEL_BITS:0]      DECODED_IMAGE [0:IMAGE_SIZE-1],
    output logic [IMAGE_SIZE_BITS:0] EVENT_COUNT,
    output logic                     IMAGE_DECODED,
    output logic                     ADDR_ERR,
    output logic                     DUP_ERR,
    output logic [1:0]               state_dbg
);
    localparam int AW = IMAGE_SIZE_BITS + 1;
    localparam int PW = PIXEL_BITS + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WRITE  = 2'd1;
    localparam logic [1:0] S_ACK_HI = 2'd2;
    localparam logic [1:0] S_ACK_LO = 2'd3;

    logic [1:0]                 state;
    logic                       req_m;
    logic                       req_s;
    logic [AW-1:0]              addr_q;
    logic                       ack_q;
    logic [IMAGE_SIZE-1:0]      written;
    logic [IMAGE_SIZE_BITS-1:0] idx;
    logic                       addr_ok;
    logic                       is_dup;
    logic [PW-1:0]              rank_val;
    int                         rank_diff;

    always_comb begin
        idx       = addr_q[IMAGE_SIZE_BITS-1:0];
        addr_ok   = (addr_q < AW'(IMAGE_SIZE));
        is_dup    = addr_ok && written[idx];
        // Ranks beyond the intensity range saturate to zero instead of wrapping.
        rank_diff = PIXEL_MAX_VALUE - int'(EVENT_COUNT);
        rank_val  = (rank_diff < 0) ? '0 : PW'(rank_diff);
    end

    // Handshake FSM; ACK comes straight from a flop so it cannot glitch.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            req_m  <= 1'b0;
            req_s  <= 1'b0;
            state  <= S_IDLE;
            addr_q <= '0;
            ack_q  <= 1'b0;
        end else begin
            req_m <= AERIN.AERIN_REQ;
            req_s <= req_m;
            case (state)
                S_IDLE: begin
                    if (req_s) begin
                        addr_q <= AERIN.AERIN_ADDR;
                        state  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    ack_q <= 1'b1;
                    state <= S_ACK_HI;
                end
                S_ACK_HI: begin
                    if (!req_s) begin
                        ack_q <= 1'b0;
                        state <= S_ACK_LO;
                    end
                end
                S_ACK_LO: state <= S_IDLE;
                default: begin
                    ack_q <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Image store; a frame clear wins over a coincident write, which is then dropped.
    always_ff @(posedge CLK) begin
        if (!RST || NEW_FRAME) begin
            for (int i = 0; i < IMAGE_SIZE; i++) DECODED_IMAGE[i] <= '0;
            written       <= '0;
            EVENT_COUNT   <= '0;
            IMAGE_DECODED <= 1'b0;
            ADDR_ERR      <= 1'b0;
            DUP_ERR       <= 1'b0;
        end else if (state == S_WRITE) begin
            if (!addr_ok) begin
                ADDR_ERR <= 1'b1;
            end else if (is_dup || EVENT_COUNT == AW'(IMAGE_SIZE)) begin
                DUP_ERR <= 1'b1;
            end else begin
                DECODED_IMAGE[idx] <= rank_val;
                written[idx]       <= 1'b1;
                EVENT_COUNT        <= EVENT_COUNT + AW'(1);
                if (EVENT_COUNT == AW'(IMAGE_SIZE - 1)) IMAGE_DECODED <= 1'b1;
            end
        end
    end

    assign AERIN.AERIN_ACK = ack_q;
    assign state_dbg       = state;

endmodule
